// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: single-car elevator controller using a SCAN policy.
// Hall and car calls are latched into a pending bitmap. The car keeps moving
// in one direction while calls lie ahead of it, then reverses.
// Floor travel and door dwell are timed by one shared cycle counter.
// Optional feature: define ELEV_FIRE_RECALL_EN to add the fire-recall input
// `recall`, which sends the car to floor 0 and holds the door open there.
module elevator_scan_ctrl #(
   parameter int NUM_FLOORS    = 16,
   parameter int FLOOR_W       = $clog2(NUM_FLOORS),
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  call_valid,
   input  logic [FLOOR_W-1:0]    call_floor,
`ifdef ELEV_FIRE_RECALL_EN
   input  logic                  recall,
`endif
   output logic                  call_err,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic                  door_open,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  arrived,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TMR_W-1:0]   TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
   localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
   typedef enum logic {UP, DOWN} dir_t;

   state_t                  state;
   dir_t                    dir;
   logic [TMR_W-1:0]        timer;
   logic                    recall_hold;

   logic                    recall_active;
   logic                    call_in_range;
   logic                    call_ok;
   logic                    call_here;
   logic [FLOOR_W-1:0]      next_floor;
   logic                    any_above;
   logic                    any_below;
   logic                    next_hit;
   logic                    arrive_hit;
   logic                    ahead;
   logic                    behind;
   logic [NUM_FLOORS-1:0]   set_vec;
   logic [NUM_FLOORS-1:0]   clr_vec;
   logic [NUM_FLOORS-1:0]   pending_next;

`ifdef ELEV_FIRE_RECALL_EN
   assign recall_active = recall;
`else
   assign recall_active = 1'b0;
`endif

   // A call for the floor the car is parked at (door open) only reopens or
   // extends the door; it never becomes a pending request.
   assign call_in_range = {1'b0, call_floor} < FLOOR_LIMIT;
   assign call_ok       = call_valid && call_in_range && !recall_active;
   assign call_here     = call_ok && (call_floor == cur_floor) && (state != MOVE);
   assign next_floor    = (dir == UP) ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
   assign ahead         = (dir == UP) ? any_above : any_below;
   assign behind        = (dir == UP) ? any_below : any_above;

   // Door/motion outputs as a function of the state being entered, so they
   // are registered together with the state itself.
   function automatic logic [2:0] drive_outputs(input state_t s, input dir_t d);
      return {s != MOVE, (s == MOVE) && (d == UP), (s == MOVE) && (d == DOWN)};
   endfunction

   // Scan the bitmap for calls above/below the car, decide whether the floor
   // being stepped onto must be served, and build the next pending bitmap.
   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      next_hit  = 1'b0;
      set_vec   = '0;
      clr_vec   = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (FLOOR_W'(i) > cur_floor) any_above = any_above | pending[i];
         if (FLOOR_W'(i) < cur_floor) any_below = any_below | pending[i];
         if (FLOOR_W'(i) == next_floor) begin
            next_hit   = pending[i];
            clr_vec[i] = 1'b1;
         end
         if (FLOOR_W'(i) == call_floor) set_vec[i] = call_ok && !call_here;
      end
      if (call_ok && (call_floor == next_floor)) next_hit = 1'b1;
      arrive_hit = (state == MOVE) && (timer == '0) && next_hit && !recall_active;
      if (recall_active)   pending_next = '0;
      else if (arrive_hit) pending_next = (pending | set_vec) & ~clr_vec;
      else                 pending_next = pending | set_vec;
   end

   // Main controller FSM: IDLE waits for calls, MOVE steps floor by floor,
   // DOOR dwells and then picks the next SCAN direction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         dir         <= UP;
         cur_floor   <= '0;
         pending     <= '0;
         timer       <= '0;
         recall_hold <= 1'b0;
         door_open   <= 1'b1;
         moving_up   <= 1'b0;
         moving_down <= 1'b0;
         arrived     <= 1'b0;
         call_err    <= 1'b0;
      end else begin
         pending  <= pending_next;
         arrived  <= arrive_hit;
         call_err <= call_valid && !call_in_range && !recall_active;
         case (state)
            IDLE: begin
               if (recall_active) begin
                  if (cur_floor == '0) begin
                     state       <= DOOR;
                     recall_hold <= 1'b1;
                     {door_open, moving_up, moving_down} <= drive_outputs(DOOR, dir);
                  end else begin
                     state <= MOVE;
                     dir   <= DOWN;
                     timer <= TRAVEL_LOAD;
                     {door_open, moving_up, moving_down} <= drive_outputs(MOVE, DOWN);
                  end
               end else if (call_here) begin
                  state <= DOOR;
                  timer <= DOOR_LOAD;
                  {door_open, moving_up, moving_down} <= drive_outputs(DOOR, dir);
               end else if (pending != '0) begin
                  state <= MOVE;
                  dir   <= any_above ? UP : DOWN;
                  timer <= TRAVEL_LOAD;
                  {door_open, moving_up, moving_down} <= drive_outputs(MOVE, any_above ? UP : DOWN);
               end
            end
            MOVE: begin
               if (timer != '0) begin
                  timer <= timer - TMR_W'(1);
               end else begin
                  cur_floor <= next_floor;
                  if (recall_active) begin
                     dir <= DOWN;
                     if (next_floor == '0) begin
                        state       <= DOOR;
                        recall_hold <= 1'b1;
                        {door_open, moving_up, moving_down} <= drive_outputs(DOOR, DOWN);
                     end else begin
                        timer <= TRAVEL_LOAD;
                        {door_open, moving_up, moving_down} <= drive_outputs(MOVE, DOWN);
                     end
                  end else if (arrive_hit) begin
                     state <= DOOR;
                     timer <= DOOR_LOAD;
                     {door_open, moving_up, moving_down} <= drive_outputs(DOOR, dir);
                  end else begin
                     timer <= TRAVEL_LOAD;
                  end
               end
            end
            DOOR: begin
               if (recall_active) begin
                  if (cur_floor == '0) begin
                     recall_hold <= 1'b1;
                  end else begin
                     state <= MOVE;
                     dir   <= DOWN;
                     timer <= TRAVEL_LOAD;
                     {door_open, moving_up, moving_down} <= drive_outputs(MOVE, DOWN);
                  end
               end else if (recall_hold) begin
                  state       <= IDLE;
                  recall_hold <= 1'b0;
                  {door_open, moving_up, moving_down} <= drive_outputs(IDLE, dir);
               end else if (call_here) begin
                  timer <= DOOR_LOAD;
               end else if (timer != '0) begin
                  timer <= timer - TMR_W'(1);
               end else if (ahead) begin
                  state <= MOVE;
                  timer <= TRAVEL_LOAD;
                  {door_open, moving_up, moving_down} <= drive_outputs(MOVE, dir);
               end else if (behind) begin
                  state <= MOVE;
                  dir   <= (dir == UP) ? DOWN : UP;
                  timer <= TRAVEL_LOAD;
                  {door_open, moving_up, moving_down} <= drive_outputs(MOVE, (dir == UP) ? DOWN : UP);
               end else begin
                  state <= IDLE;
                  {door_open, moving_up, moving_down} <= drive_outputs(IDLE, dir);
               end
            end
            default: begin
               state <= IDLE;
               {door_open, moving_up, moving_down} <= drive_outputs(IDLE, dir);
            end
         endcase
      end
   end

endmodule
